pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Self-running instruction-fetch front end. A program counter issues
//   in-order requests to instruction memory. Returned words are paired with
//   their PC and buffered in a small FIFO. The decode stage drains the FIFO
//   over a valid/ready handshake. A redirect flushes the buffer and marks
//   every in-flight response as stale, so those responses are dropped when
//   they return.
//
//   Optional build macro: FETCH_PERF_EN adds the perf_fetched and
//   perf_dropped saturating event counters.
//
// Parameters
//   ADDR_W   : PC / memory address width
//   DATA_W   : instruction word width
//   DEPTH    : FIFO entries plus outstanding requests combined (power of 2, >=2)
//   RESET_PC : PC loaded on reset
//   PC_STEP  : PC increment per sequential fetch
//
// Ports
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr  : fetch request channel
//   imem_rsp_valid/data        : in-order response channel, no backpressure
//   out_valid/ready/pc/instr   : buffered {pc, instr} towards decode
//   redirect_valid/pc          : taken branch/jump, new target PC
//   perf_fetched/perf_dropped  : event counters (FETCH_PERF_EN only)
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              redirect_valid,
`ifdef FETCH_PERF_EN
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`else
  input  logic [ADDR_W-1:0] redirect_pc
`endif
);

  localparam int unsigned       PTR_W     = $clog2(DEPTH);
  localparam int unsigned       CNT_W     = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  typedef enum logic {
    S_RESET,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   fifo_pc_q    [DEPTH];
  logic [DATA_W-1:0]   fifo_instr_q [DEPTH];

  logic                run;
  logic [CNT_W:0]      occupancy;
  logic                req_fire;
  logic                rsp_fire;
  logic                rsp_drop;
  logic                push;
  logic                pop;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign run       = (state_q == S_RUN);
  // Buffered words plus outstanding requests never exceed DEPTH, so every
  // response that returns has a free FIFO slot waiting for it.
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};

  assign imem_req_valid = run && !redirect_valid && (occupancy < DEPTH_OCC);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding (e.g. one issued before a reset) is
  // not ours and is ignored outright.
  assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
  assign rsp_drop = rsp_fire && (drop_cnt_q != '0);
  assign push     = rsp_fire && !rsp_drop && !redirect_valid;

  assign out_valid = (count_q != '0);
  assign out_pc    = fifo_pc_q[rd_ptr_q];
  assign out_instr = fifo_instr_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    unique case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_RESET;
    endcase

    if (redirect_valid) begin
      // Every request still outstanding after this cycle's response is stale.
      drop_cnt_d = inflight_q - CNT_W'(rsp_fire);
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + STEP;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers and FIFO storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc_q[PTR_W'(i)]    <= '0;
        fifo_instr_q[PTR_W'(i)] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
        fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0]    perf_fetched_q, perf_fetched_d;
  logic [31:0]    perf_dropped_q, perf_dropped_d;
  logic [CNT_W:0] dropped_inc;
  logic [32:0]    fetched_sum;
  logic [32:0]    dropped_sum;

  always_comb begin
    dropped_inc = '0;
    // A response returning in a redirect cycle is discarded whether or not it
    // was already marked stale; the popped head of a flush is consumed.
    if (rsp_fire && (rsp_drop || redirect_valid)) begin
      dropped_inc = dropped_inc + 1'b1;
    end
    if (redirect_valid) begin
      dropped_inc = dropped_inc + {1'b0, count_q - CNT_W'(pop)};
    end
    fetched_sum    = {1'b0, perf_fetched_q} + 33'(pop);
    dropped_sum    = {1'b0, perf_dropped_q} + 33'(dropped_inc);
    perf_fetched_d = fetched_sum[32] ? '1 : fetched_sum[31:0];
    perf_dropped_d = dropped_sum[32] ? '1 : dropped_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Randomised bench for pc_fetch_unit. A memory model returns words in
//   order with a per-request latency. The reference tracks the expected
//   {pc, instr} stream with an epoch tag per redirect: responses from an old
//   epoch never reach the output, and the buffer is a plain queue.
//   A second instance (ADDR_W = 8, RESET_PC = 0xF8) covers PC wrap.
module tb_pc_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        out_valid, out_ready, redirect_valid;
  logic [31:0] out_pc, out_instr, redirect_pc;

  logic        w_req_valid, w_req_ready, w_rsp_valid;
  logic [7:0]  w_req_addr;
  logic [31:0] w_rsp_data;
  logic        w_out_valid, w_out_ready, w_redirect_valid;
  logic [7:0]  w_out_pc, w_redirect_pc;
  logic [31:0] w_out_instr;

  pc_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  pc_fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(8'hF8), .PC_STEP(4)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_pc(w_out_pc), .out_instr(w_out_instr),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mreq_t       memq[$];
  logic [31:0] orphan_q[$];
  ent_t        expq[$];
  int          cyc = 0, last_due = 0, epoch = 0;
  logic [31:0] next_pc;
  bit          in_reset_state;
  int          checks = 0, errors = 0;

  logic        o_req_valid, o_out_valid, e_req_valid, e_out_valid;
  logic [31:0] o_req_addr, o_out_pc, o_out_instr, e_req_addr, e_out_pc, e_out_instr;
  int          s_cyc;

  // One clock of stimulus: present memory response, apply inputs, sample
  // outputs, then advance the reference by the handshakes it predicts.
  task automatic step(input bit rdy, input bit ordy, input bit redir,
                      input logic [31:0] rpc, input int lat);
    bit rsp_real, rsp_orph, fire, pop;
    mreq_t r;
    ent_t e;
    rsp_real = (memq.size() > 0) && (memq[0].due == cyc);
    rsp_orph = !rsp_real && (orphan_q.size() > 0);
    imem_rsp_valid = rsp_real || rsp_orph;
    if (rsp_real)      imem_rsp_data = instr_of(memq[0].addr);
    else if (rsp_orph) imem_rsp_data = instr_of(orphan_q[0]);
    else               imem_rsp_data = $urandom;
    imem_req_ready = rdy; out_ready = ordy; redirect_valid = redir; redirect_pc = rpc;
    #1;
    s_cyc = cyc;
    o_req_valid = imem_req_valid; o_req_addr = imem_req_addr;
    o_out_valid = out_valid; o_out_pc = out_pc; o_out_instr = out_instr;
    e_out_valid = (expq.size() > 0);
    e_out_pc    = e_out_valid ? expq[0].pc : 32'h0;
    e_out_instr = e_out_valid ? expq[0].instr : 32'h0;
    e_req_valid = !in_reset_state && !redir && ((expq.size() + memq.size()) < DEPTH);
    e_req_addr  = next_pc;
    fire = e_req_valid && rdy;
    pop  = e_out_valid && ordy;
    if (pop) void'(expq.pop_front());
    if (rsp_real) begin
      r = memq.pop_front();
      if (r.epoch == epoch && !redir) begin
        e.pc = r.addr; e.instr = instr_of(r.addr); expq.push_back(e);
      end
    end else if (rsp_orph) begin
      void'(orphan_q.pop_front());
    end
    if (redir) begin
      expq.delete(); epoch++; next_pc = rpc;
    end
    if (fire) begin
      r.addr = next_pc;
      r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      r.epoch = epoch;
      memq.push_back(r);
      last_due = r.due;
      next_pc = next_pc + 32'd4;
    end
    in_reset_state = 1'b0;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    expq.delete(); epoch++; next_pc = 32'h0; in_reset_state = 1'b1; last_due = cyc;
  endtask

  task automatic fresh_reset();
    rst_n = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    memq.delete(); orphan_q.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = '0; w_out_ready = 1'b0;
    w_redirect_valid = 1'b0; w_redirect_pc = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, out_valid, out_pc, out_instr} !== 66'h0) begin
      errors++;
      $display("FAIL reset_outputs got req_valid=%b out_valid=%b pc=%h instr=%h required all 0",
               imem_req_valid, out_valid, out_pc, out_instr);
    end
    checks++;
    if ({w_req_valid, w_out_valid, w_out_pc} !== 10'h0) begin
      errors++;
      $display("FAIL reset_outputs_w got req_valid=%b out_valid=%b pc=%h required all 0",
               w_req_valid, w_out_valid, w_out_pc);
    end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    model_reset();
    step(1, 1, 0, 0, 1);
    checks++;
    if (o_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_req got req_valid=%b required 0", o_req_valid);
    end
  endtask

  task automatic test_wrap();
    bit pend = 1'b0;
    logic [7:0] pend_addr = '0;
    logic [7:0] got_pc[$];
    logic [31:0] got_in[$];
    logic [7:0] wexp[4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    w_req_ready = 1'b1; w_out_ready = 1'b1; w_redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      w_rsp_valid = pend;
      w_rsp_data = instr_of({24'h0, pend_addr});
      #1;
      if (w_out_valid) begin got_pc.push_back(w_out_pc); got_in.push_back(w_out_instr); end
      pend = w_req_valid;
      pend_addr = w_req_addr;
      @(posedge clk); #1;
    end
    w_rsp_valid = 1'b0; w_req_ready = 1'b0;
    checks++;
    if (got_pc.size() < 4) begin
      errors++;
      $display("FAIL wrap_count got %0d outputs required >=4", got_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_pc[i] !== wexp[i] || got_in[i] !== instr_of({24'h0, wexp[i]})) begin
          errors++;
          $display("FAIL wrap_seq[%0d] got pc=%h instr=%h required pc=%h instr=%h",
                   i, got_pc[i], got_in[i], wexp[i], instr_of({24'h0, wexp[i]}));
        end
      end
    end
  endtask

  task automatic test_sequential();
    int fire_cyc = -1, valid_cyc = -1;
    logic [31:0] pops[$];
    int pop_cyc[$];
    fresh_reset();
    for (int i = 0; i < 14; i++) begin
      step(1, 1, 0, 0, 1);
      checks++;
      if ({o_req_valid, o_req_valid ? o_req_addr : 32'h0} !== {e_req_valid, e_req_valid ? e_req_addr : 32'h0}) begin
        errors++;
        $display("FAIL seq_req cyc=%0d got v=%b a=%h required v=%b a=%h", s_cyc, o_req_valid, o_req_addr, e_req_valid, e_req_addr);
      end
      checks++;
      if ({o_out_valid, o_out_valid ? {o_out_pc, o_out_instr} : 64'h0} !== {e_out_valid, e_out_pc, e_out_instr}) begin
        errors++;
        $display("FAIL seq_out cyc=%0d got v=%b pc=%h i=%h required v=%b pc=%h i=%h", s_cyc, o_out_valid, o_out_pc, o_out_instr, e_out_valid, e_out_pc, e_out_instr);
      end
      if (o_req_valid && fire_cyc < 0) fire_cyc = s_cyc;
      if (o_out_valid && valid_cyc < 0) valid_cyc = s_cyc;
      if (o_out_valid) begin pops.push_back(o_out_pc); pop_cyc.push_back(s_cyc); end
    end
    checks++;
    if (valid_cyc - fire_cyc !== 2) begin
      errors++;
      $display("FAIL seq_latency got %0d cycles required 2", valid_cyc - fire_cyc);
    end
    checks++;
    if (pops.size() < 4 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8 ||
        pops[3] !== 32'hC || pop_cyc[3] - pop_cyc[0] !== 3) begin
      errors++;
      $display("FAIL seq_order got %p required 0,4,8,12 on consecutive cycles", pops);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pops[$];
    fresh_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 1);
      checks++;
      if ({o_req_valid, o_req_valid ? o_req_addr : 32'h0} !== {e_req_valid, e_req_valid ? e_req_addr : 32'h0}) begin
        errors++;
        $display("FAIL bp_req cyc=%0d got v=%b a=%h required v=%b a=%h", s_cyc, o_req_valid, o_req_addr, e_req_valid, e_req_addr);
      end
      checks++;
      if ({o_out_valid, o_out_valid ? {o_out_pc, o_out_instr} : 64'h0} !== {e_out_valid, e_out_pc, e_out_instr}) begin
        errors++;
        $display("FAIL bp_out cyc=%0d got v=%b pc=%h i=%h required v=%b pc=%h i=%h", s_cyc, o_out_valid, o_out_pc, o_out_instr, e_out_valid, e_out_pc, e_out_instr);
      end
    end
    checks++;
    if ({o_req_valid, o_out_valid, o_out_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bp_hold got req_valid=%b out_valid=%b pc=%h required 0 1 0", o_req_valid, o_out_valid, o_out_pc);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 1);
      checks++;
      if ({o_out_valid, o_out_valid ? {o_out_pc, o_out_instr} : 64'h0} !== {e_out_valid, e_out_pc, e_out_instr}) begin
        errors++;
        $display("FAIL bp_drain cyc=%0d got v=%b pc=%h required v=%b pc=%h", s_cyc, o_out_valid, o_out_pc, e_out_valid, e_out_pc);
      end
      if (o_out_valid) pops.push_back(o_out_pc);
    end
    checks++;
    if (pops.size() < 5 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8 ||
        pops[3] !== 32'hC || pops[4] !== 32'h10) begin
      errors++;
      $display("FAIL bp_order got %p required 0,4,8,12,16", pops);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] pops[$];
    fresh_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 3);
    step(1, 0, 1, 32'h100, 3);
    checks++;
    if ({o_req_valid, o_out_valid, o_out_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL redir_cycle got req_valid=%b out_valid=%b pc=%h required 0 1 0", o_req_valid, o_out_valid, o_out_pc);
    end
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0, $urandom_range(1, 3));
      if (i == 0) begin
        checks++;
        if (o_out_valid !== 1'b0) begin
          errors++;
          $display("FAIL redir_flush got out_valid=%b required 0", o_out_valid);
        end
      end
      checks++;
      if ({o_req_valid, o_req_valid ? o_req_addr : 32'h0, o_out_valid, o_out_valid ? {o_out_pc, o_out_instr} : 64'h0} !==
          {e_req_valid, e_req_valid ? e_req_addr : 32'h0, e_out_valid, e_out_pc, e_out_instr}) begin
        errors++;
        $display("FAIL redir_stream cyc=%0d got rv=%b ra=%h ov=%b pc=%h required rv=%b ra=%h ov=%b pc=%h",
                 s_cyc, o_req_valid, o_req_addr, o_out_valid, o_out_pc, e_req_valid, e_req_addr, e_out_valid, e_out_pc);
      end
      if (o_out_valid) pops.push_back(o_out_pc);
    end
    checks++;
    if (pops.size() == 0 || pops[0] !== 32'h100) begin
      errors++;
      $display("FAIL redir_target got %p required first 00000100", pops);
    end
    foreach (pops[i]) begin
      checks++;
      if (pops[i] inside {32'h8, 32'hC, 32'h10, 32'h14}) begin
        errors++;
        $display("FAIL redir_stale got pc=%h required no stale pc", pops[i]);
      end
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] pops[$];
    fresh_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 2);
    step(1, 1, 1, 32'h40, 2);
    checks++;
    if ({o_out_valid, imem_rsp_valid} !== 2'b11) begin
      errors++;
      $display("FAIL rpop_setup got out_valid=%b rsp_valid=%b required 1 1", o_out_valid, imem_rsp_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 2);
      checks++;
      if ({o_req_valid, o_req_valid ? o_req_addr : 32'h0, o_out_valid, o_out_valid ? {o_out_pc, o_out_instr} : 64'h0} !==
          {e_req_valid, e_req_valid ? e_req_addr : 32'h0, e_out_valid, e_out_pc, e_out_instr}) begin
        errors++;
        $display("FAIL rpop_stream cyc=%0d got rv=%b ra=%h ov=%b pc=%h required rv=%b ra=%h ov=%b pc=%h",
                 s_cyc, o_req_valid, o_req_addr, o_out_valid, o_out_pc, e_req_valid, e_req_addr, e_out_valid, e_out_pc);
      end
      if (o_out_valid) pops.push_back(o_out_pc);
    end
    checks++;
    if (pops.size() < 2 || pops[0] !== 32'h40 || pops[1] !== 32'h44) begin
      errors++;
      $display("FAIL rpop_target got %p required 40,44", pops);
    end
  endtask

  task automatic test_random();
    fresh_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           $urandom & 32'hFFFF_FFFC, $urandom_range(1, 4));
      checks++;
      if ({o_req_valid, o_req_valid ? o_req_addr : 32'h0, o_out_valid, o_out_valid ? {o_out_pc, o_out_instr} : 64'h0} !==
          {e_req_valid, e_req_valid ? e_req_addr : 32'h0, e_out_valid, e_out_pc, e_out_instr}) begin
        errors++;
        $display("FAIL rand_stream cyc=%0d got rv=%b ra=%h ov=%b pc=%h i=%h required rv=%b ra=%h ov=%b pc=%h i=%h",
                 s_cyc, o_req_valid, o_req_addr, o_out_valid, o_out_pc, o_out_instr,
                 e_req_valid, e_req_addr, e_out_valid, e_out_pc, e_out_instr);
      end
    end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] pops[$];
    fresh_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 3);
    checks++;
    if ({out_valid, memq.size() == 3} !== 2'b11) begin
      errors++;
      $display("FAIL mid_setup got out_valid=%b inflight=%0d required 1 3", out_valid, memq.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, out_valid, out_pc, out_instr} !== 66'h0) begin
      errors++;
      $display("FAIL mid_async_clear got req_valid=%b out_valid=%b pc=%h instr=%h required all 0",
               imem_req_valid, out_valid, out_pc, out_instr);
    end
    imem_rsp_valid = 1'b0;
    foreach (memq[i]) orphan_q.push_back(memq[i].addr);
    memq.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      if (orphan_q.size() > 0 || i < 4) step(0, 1, 0, 0, 1);
      else step(1, 1, 0, 0, 1);
      checks++;
      if ({o_req_valid, o_req_valid ? o_req_addr : 32'h0, o_out_valid, o_out_valid ? {o_out_pc, o_out_instr} : 64'h0} !==
          {e_req_valid, e_req_valid ? e_req_addr : 32'h0, e_out_valid, e_out_pc, e_out_instr}) begin
        errors++;
        $display("FAIL mid_restart cyc=%0d got rv=%b ra=%h ov=%b pc=%h required rv=%b ra=%h ov=%b pc=%h",
                 s_cyc, o_req_valid, o_req_addr, o_out_valid, o_out_pc, e_req_valid, e_req_addr, e_out_valid, e_out_pc);
      end
      if (o_out_valid) pops.push_back(o_out_pc);
    end
    checks++;
    if (pops.size() < 3 || pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8) begin
      errors++;
      $display("FAIL mid_order got %p required 0,4,8", pops);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got no finish required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
